// File: rtl/huffman_bitpack.sv
// Variable-length code packer: concatenates (code, length) pairs MSB-first into
// OUT_WIDTH-bit words and emits a zero-padded, bit-counted final word per stream.
module huffman_bitpack #(
  parameter int CODE_WIDTH = 32,
  parameter int LEN_WIDTH  = 6,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         code_i_valid,
  output logic                         code_i_ready,
  input  logic [CODE_WIDTH-1:0]        code_i_data,
  input  logic [LEN_WIDTH-1:0]         code_i_len,
  input  logic                         code_i_last,
  output logic                         fifo_o_valid,
  input  logic                         fifo_o_ready,
  output logic [OUT_WIDTH-1:0]         fifo_o_data,
  output logic [$clog2(OUT_WIDTH):0]   fifo_o_bits,
  output logic                         fifo_o_last
);

  localparam int ACC_W  = OUT_WIDTH + CODE_WIDTH;
  localparam int CNT_W  = $clog2(ACC_W);
  localparam int BITS_W = $clog2(OUT_WIDTH) + 1;

  localparam logic [CNT_W-1:0]     OUT_CNT  = CNT_W'(OUT_WIDTH);
  localparam logic [LEN_WIDTH-1:0] CODE_LEN = LEN_WIDTH'(CODE_WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_d;

  logic [LEN_WIDTH-1:0]  len_c;
  logic [LEN_WIDTH-1:0]  pad_amt;
  logic [CODE_WIDTH-1:0] code_mask;
  logic [ACC_W-1:0]      code_ext;
  logic [ACC_W-1:0]      placed;

  logic                  accept;
  logic                  slot_free;
  logic                  load;
  logic [OUT_WIDTH-1:0]  load_data;
  logic [BITS_W-1:0]     load_bits;
  logic                  load_last;

  // Clamp the length, mask junk above it, then left-align the code at the
  // current fill point (bit len-1 lands at acc[ACC_W-1-cnt]).
  assign len_c     = (code_i_len > CODE_LEN) ? CODE_LEN : code_i_len;
  assign pad_amt   = CODE_LEN - len_c;
  assign code_mask = {CODE_WIDTH{1'b1}} >> pad_amt;
  assign code_ext  = {code_i_data & code_mask, {OUT_WIDTH{1'b0}}};
  assign placed    = (code_ext << pad_amt) >> cnt_q;

  assign accept    = code_i_valid && code_i_ready;
  assign slot_free = !fifo_o_valid || fifo_o_ready;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; a missing default in always_comb infers a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_data = acc_q[ACC_W-1 -: OUT_WIDTH];
    load_bits = BITS_W'(OUT_WIDTH);
    load_last = 1'b0;

    case (state_q)
      IDLE: state_d = RUN;

      RUN: begin
        if (accept) begin
          acc_d = acc_q | placed;
          cnt_d = cnt_q + CNT_W'(len_c);
          if (code_i_last) state_d = FLUSH;
        end else if (cnt_q >= OUT_CNT && slot_free) begin
          load  = 1'b1;
          acc_d = acc_q << OUT_WIDTH;
          cnt_d = cnt_q - OUT_CNT;
        end
      end

      FLUSH: begin
        if (slot_free) begin
          load = 1'b1;
          // An exactly full word still goes out as a plain word; the stream is
          // then closed by a separate (possibly empty) last word.
          if (cnt_q >= OUT_CNT) begin
            acc_d = acc_q << OUT_WIDTH;
            cnt_d = cnt_q - OUT_CNT;
          end else begin
            load_bits = BITS_W'(cnt_q);
            load_last = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = RUN;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Ready is registered; the IDLE term holds it low for the first RUN cycle.
  assign ready_d = (state_d == RUN) && (cnt_d < OUT_CNT) && (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      code_i_ready <= 1'b0;
      fifo_o_valid <= 1'b0;
      fifo_o_data  <= '0;
      fifo_o_bits  <= '0;
      fifo_o_last  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      code_i_ready <= ready_d;
      if (load) begin
        fifo_o_valid <= 1'b1;
        fifo_o_data  <= load_data;
        fifo_o_bits  <= load_bits;
        fifo_o_last  <= load_last;
      end else if (fifo_o_ready) begin
        fifo_o_valid <= 1'b0;
      end
    end
  end

endmodule
